// File: rtl/zap_wb_arb_n_pkg.sv
// Shared Wishbone definitions for the zap cache-subsystem arbiters.
package zap_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_BURST   = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int unsigned WB_ADR_WDT = 32;
  localparam int unsigned WB_DAT_WDT = 32;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

endpackage

// File: rtl/zap_wb_arb_n_pick.sv
// Combinational request picker: fixed priority (highest index) or round-robin
// starting after rr_ptr. Shared with the icache top.
module zap_arb_pick
  import zap_wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  input  arb_mode_t              mode,
  output logic [NUM_MASTERS-1:0] onehot,
  output logic [IDX_W-1:0]       bin,
  output logic                   valid
);

  logic        found;
  int unsigned idx;

  always_comb begin
    bin   = '0;
    found = 1'b0;
    idx   = 0;
    valid = |req;
    if (mode == ARB_FIXED) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (req[i]) bin = IDX_W'(i);
      end
    end else begin
      for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
        idx = (32'(rr_ptr) + off) % NUM_MASTERS;
        if (!found && req[idx]) begin
          bin   = IDX_W'(idx);
          found = 1'b1;
        end
      end
    end
    onehot = valid ? (NUM_MASTERS'(1) << bin) : '0;
  end

endmodule

// File: rtl/zap_wb_arb_n.sv
// N-master Wishbone B3 arbiter/mux with registered shared bus and routed ACK/ERR.
// Optional stall watchdog enabled by defining ZAP_WB_ARB_TIMEOUT_EN.
module zap_wb_arb_n
  import zap_wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned CYC_LOCK       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [NUM_MASTERS-1:0]            i_wb_cyc_nxt,
  input  logic [NUM_MASTERS-1:0]            i_wb_stb_nxt,
  input  logic [NUM_MASTERS-1:0]            i_wb_wen_nxt,
  input  logic [4*NUM_MASTERS-1:0]          i_wb_sel_nxt,
  input  logic [WB_DAT_WDT*NUM_MASTERS-1:0] i_wb_dat_nxt,
  input  logic [WB_ADR_WDT*NUM_MASTERS-1:0] i_wb_adr_nxt,
  input  logic [3*NUM_MASTERS-1:0]          i_wb_cti_nxt,
  output logic [NUM_MASTERS-1:0]            o_wb_ack,
  output logic [NUM_MASTERS-1:0]            o_wb_err,
  output logic                              o_wb_cyc,
  output logic                              o_wb_stb,
  output logic                              o_wb_wen,
  output logic [3:0]                        o_wb_sel,
  output logic [WB_DAT_WDT-1:0]             o_wb_dat,
  output logic [WB_ADR_WDT-1:0]             o_wb_adr,
  output logic [2:0]                        o_wb_cti,
  output logic                              o_wb_cyc_nxt,
  output logic                              o_wb_stb_nxt,
  output logic                              o_wb_wen_nxt,
  output logic [3:0]                        o_wb_sel_nxt,
  output logic [WB_DAT_WDT-1:0]             o_wb_dat_nxt,
  output logic [WB_ADR_WDT-1:0]             o_wb_adr_nxt,
  output logic [2:0]                        o_wb_cti_nxt,
  input  logic                              i_wb_ack,
  input  logic                              i_wb_err,
  output logic [NUM_MASTERS-1:0]            o_grant,
  output logic                              o_timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam arb_mode_t   MODE  = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic [NUM_MASTERS-1:0] grant_ff, grant_nxt, pick_oh;
  logic [IDX_W-1:0]       grant_idx, grant_nxt_idx, pick_idx, rr_ptr;
  logic                   pick_valid, arb_ok, take, tmo;
  int unsigned            gi;

  zap_arb_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req   (i_wb_cyc_nxt),
    .rr_ptr(rr_ptr),
    .mode  (MODE),
    .onehot(pick_oh),
    .bin   (pick_idx),
    .valid (pick_valid)
  );

`ifdef ZAP_WB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo = o_wb_stb && !i_wb_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || !o_wb_stb || i_wb_ack || tmo) tmo_cnt <= '0;
    else                                          tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // A watchdog expiry acts like a completing ACK, so it also re-arbitrates.
  always_comb begin
    arb_ok = ((!o_wb_stb || i_wb_ack) &&
              ((CYC_LOCK == 0) || !i_wb_cyc_nxt[grant_idx])) || tmo;
    take          = arb_ok && pick_valid;
    grant_nxt     = take ? pick_oh  : grant_ff;
    grant_nxt_idx = take ? pick_idx : grant_idx;
    gi            = 32'(grant_nxt_idx);
    o_wb_cyc_nxt  = i_wb_cyc_nxt[gi];
    o_wb_stb_nxt  = i_wb_stb_nxt[gi];
    o_wb_wen_nxt  = i_wb_wen_nxt[gi];
    o_wb_sel_nxt  = i_wb_sel_nxt[4*gi +: 4];
    o_wb_dat_nxt  = i_wb_dat_nxt[WB_DAT_WDT*gi +: WB_DAT_WDT];
    o_wb_adr_nxt  = i_wb_adr_nxt[WB_ADR_WDT*gi +: WB_ADR_WDT];
    o_wb_cti_nxt  = i_wb_cti_nxt[3*gi +: 3];
  end

  assign o_wb_ack  = {NUM_MASTERS{i_wb_ack | tmo}} & grant_ff;
  assign o_wb_err  = {NUM_MASTERS{i_wb_err | tmo}} & grant_ff;
  assign o_grant   = grant_ff;
  assign o_timeout = tmo;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      grant_ff  <= NUM_MASTERS'(1);
      grant_idx <= '0;
      rr_ptr    <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_wen  <= 1'b0;
      o_wb_sel  <= '0;
      o_wb_dat  <= '0;
      o_wb_adr  <= '0;
      o_wb_cti  <= CTI_EOB;
    end else begin
      grant_ff  <= grant_nxt;
      grant_idx <= grant_nxt_idx;
      if (take) rr_ptr <= pick_idx;
      o_wb_cyc  <= o_wb_cyc_nxt;
      o_wb_stb  <= o_wb_stb_nxt;
      o_wb_wen  <= o_wb_wen_nxt;
      o_wb_sel  <= o_wb_sel_nxt;
      o_wb_dat  <= o_wb_dat_nxt;
      o_wb_adr  <= o_wb_adr_nxt;
      o_wb_cti  <= o_wb_cti_nxt;
    end
  end

  a_err_needs_ack: assert property (@(posedge i_clk) disable iff (i_reset)
    i_wb_err |-> i_wb_ack) else $fatal(1, "i_wb_err without i_wb_ack");
  a_grant_onehot: assert property (@(posedge i_clk) disable iff (i_reset)
    $onehot(grant_ff)) else $fatal(1, "grant_ff not one-hot");
  a_ack_needs_stb: assert property (@(posedge i_clk) disable iff (i_reset)
    i_wb_ack |-> o_wb_stb) else $fatal(1, "i_wb_ack while o_wb_stb low");

endmodule

// File: doc/zap_wb_arb_n.md
Name: zap_wb_arb_n

Overview:
- N-master Wishbone B3 arbiter/mux for cache-subsystem tops (dcache/icache), replacing the hard-wired 3-way cache/tag/TLB mux.
- Adds parametrised master count, fixed-priority or round-robin arbitration, and an optional whole-CYC grant lock.
- Masters present combinational *_nxt bus signals; the block returns registered shared bus outputs plus per-master ACK/ERR routing.

Parameters:
- NUM_MASTERS, 3, number of masters (2..8).
- ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
- CYC_LOCK, 0, 1 = the granted master keeps the grant while its cyc_nxt is high.
- TIMEOUT_CYCLES, 256, stall limit used only with the optional feature (>=2).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_wb_cyc_nxt  in  NUM_MASTERS  per-master CYC
- i_wb_stb_nxt  in  NUM_MASTERS  per-master STB
- i_wb_wen_nxt  in  NUM_MASTERS  per-master WE
- i_wb_sel_nxt  in  4*NUM_MASTERS  per-master SEL, master k at [4k+:4]
- i_wb_dat_nxt  in  32*NUM_MASTERS  per-master write data
- i_wb_adr_nxt  in  32*NUM_MASTERS  per-master address
- i_wb_cti_nxt  in  3*NUM_MASTERS  per-master CTI
- o_wb_ack  out  NUM_MASTERS  routed ACK
- o_wb_err  out  NUM_MASTERS  routed ERR
- o_wb_cyc/stb/wen/sel/dat/adr/cti  out  1/1/1/4/32/32/3  registered shared bus
- o_wb_cyc_nxt .. o_wb_cti_nxt  out  same widths  combinational next-state of the bus
- i_wb_ack  in  1  slave ACK
- i_wb_err  in  1  slave ERR (valid only with ACK)
- o_grant  out  NUM_MASTERS  one-hot current grant (grant_ff)
- o_timeout  out  1  timeout pulse (tied 0 without the feature)

Behaviour:
- Single clock i_clk; reset is synchronous, active-high on i_reset.
- Reset values:
  - grant_ff = master 0; rr_ptr = 0.
  - o_wb_cyc = 0, o_wb_stb = 0, o_wb_cti = CTI_EOB (3'b111).
  - o_wb_adr/dat/sel = 0, o_wb_wen = 0.
  - o_wb_ack = 0, o_wb_err = 0, o_timeout = 0.
- Arbitration point: arb_ok = (!o_wb_stb || i_wb_ack) && (!CYC_LOCK || !i_wb_cyc_nxt[granted]).
  - If !arb_ok: grant_nxt = grant_ff.
- Fixed priority: grant_nxt = highest index k with i_wb_cyc_nxt[k]=1.
- Round-robin: grant_nxt = first k with cyc_nxt[k]=1, searching rr_ptr+1 .. rr_ptr+NUM_MASTERS, modulo NUM_MASTERS.
  - rr_ptr <= index of grant_nxt, updated only when arb_ok and some request exists.
- No requester at an arbitration point: grant held.
- Bus mux: o_wb_*_nxt = master[grant_nxt] signals. Registered outputs load *_nxt every cycle. Zero cycles of added latency beyond the output register.
- Routing is combinational, not registered:
  - o_wb_ack[k] = i_wb_ack & grant_ff[k]
  - o_wb_err[k] = i_wb_err & grant_ff[k]
- A completing ACK and a new grant in the same cycle: the ACK goes to the old master (grant_ff); the new master drives the bus next cycle.
- Simultaneous requests under fixed priority: highest index wins; lower masters starve until it drops cyc_nxt.
- Reset mid-transfer: bus drops immediately (next edge); any in-flight ACK is ignored.
- Simulation assertions (fatal):
  - i_wb_err without i_wb_ack.
  - grant_ff not one-hot.
  - i_wb_ack while o_wb_stb = 0.

Optional Feature:
- Macro: ZAP_WB_ARB_TIMEOUT_EN.
- With it defined:
  - Counter (width $clog2(TIMEOUT_CYCLES+1)) increments each cycle o_wb_stb=1 && !i_wb_ack; it clears on ACK, on stb low, or on reset.
  - When the count reaches TIMEOUT_CYCLES-1, for one cycle: synthetic ack+err to the granted master (o_wb_err[k]=o_wb_ack[k]=1), and o_timeout=1.
  - That cycle counts as an arbitration point; the counter clears.
- Without it: no counter; o_timeout tied 0.

Decomposition:
- Package zap_wb_pkg holds:
  - CTI_CLASSIC, CTI_BURST, CTI_EOB constants.
  - arb_mode_t enum {ARB_FIXED, ARB_RR}.
  - WB_ADR_WDT = 32, WB_DAT_WDT = 32.
- Sub-module zap_arb_pick: combinational picker with inputs req, rr_ptr, mode and output one-hot plus binary grant. Reusable by the icache top.

Test Plan:
- N=3, fixed: cyc_nxt=3'b011 at reset → grant 3'b010 on the first edge. Raise cyc_nxt[2] while o_wb_stb=1 with no ack → grant unchanged. Ack → grant 3'b100 next edge.
- N=3, RR: all three request continuously, each single-beat with ack every 2nd cycle → grants cycle 1,2,0,1,2,0; o_wb_ack routes only to grant_ff.
- CYC_LOCK=1: master 0 runs a 4-beat burst (CTI 010,010,010,111); master 2 requests at beat 1 → master 0 keeps the grant until cyc_nxt[0] falls; master 2 is granted the following cycle.
- Ack+err on adr 0x0000_1000 from master 1 → o_wb_err=3'b010 and o_wb_ack=3'b010 for one cycle; no other master sees err.
- ZAP_WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: stb held, no ack → at cycle 7, o_timeout=1 and o_wb_err[granted]=1; counter clears; re-arbitration happens.
- Reset asserted mid-burst → next edge o_wb_cyc=0, o_wb_stb=0, o_wb_cti=3'b111, grant=3'b001.
